// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequencer for an external 8-bit up-counter.
// It loads the counter with a latched preset, enables counting until the
// counter reads 8'hFF, then either finishes (one-shot) or reloads (auto-reload).
// Optional macro CNT_SEQ_CTRL_PAUSE_EN adds a pause input that freezes RUN.
// Ports:
//   clk        clock, rising edge
//   mr         synchronous active-low reset
//   start      begin a sequence (sampled in IDLE only)
//   stop       abort, effective in every state
//   mode       0 one-shot, 1 auto-reload (latched on start)
//   pause      (CNT_SEQ_CTRL_PAUSE_EN only) hold RUN, counter disabled
//   preset     counter start value (latched on start)
//   cnt_q      current counter value
//   cnt_load_n active-low counter load
//   cnt_en     counter enable
//   cnt_d      counter load value (latched preset)
//   busy       high in LOAD and RUN
//   done       one-cycle pulse after each completed period
//   run_count  periods completed since the last accepted start
module cnt_seq_ctrl (
  input  logic       clk,
  input  logic       mr,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
`ifdef CNT_SEQ_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [7:0] preset,
  input  logic [7:0] cnt_q,
  output logic       cnt_load_n,
  output logic       cnt_en,
  output logic [7:0] cnt_d,
  output logic       busy,
  output logic       done,
  output logic [7:0] run_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] preset_lat;
  logic             mode_lat;
  logic             hold;
  logic             term;
  logic             period_end;
  logic             accept;

`ifdef CNT_SEQ_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Terminal count is decoded from the counter value, never from a carry.
  assign term       = (state == RUN) && (cnt_q == {CNT_W{1'b1}}) && !hold;
  // A stop in the terminal cycle cancels the period completion.
  assign period_end = term && !stop;
  assign accept     = (state == IDLE) && start && !stop;

  // State register
  always_ff @(posedge clk) begin
    if (!mr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded counter controls
  always_comb begin
    state_nxt  = state;
    cnt_load_n = 1'b1;
    cnt_en     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_load_n = 1'b0;
        busy       = 1'b1;
        state_nxt  = stop ? IDLE : RUN;
      end
      RUN: begin
        cnt_en = !hold;
        busy   = 1'b1;
        if (stop)      state_nxt = IDLE;
        else if (term) state_nxt = mode_lat ? LOAD : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched configuration, done pulse and period counter
  always_ff @(posedge clk) begin
    if (!mr) begin
      done       <= 1'b0;
      run_count  <= '0;
      preset_lat <= '0;
      mode_lat   <= 1'b0;
    end else begin
      done <= period_end;
      if (accept) begin
        preset_lat <= preset;
        mode_lat   <= mode;
        run_count  <= '0;
      end else if (period_end) begin
        run_count <= run_count + CNT_W'(1);
      end
    end
  end

  assign cnt_d = preset_lat;

endmodule
